// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB initiator behind a valid/ready command port
module apb_master_bridge #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic        PREADY,
  input  logic [31:0] PRDATA
);

  // Counter only needs to reach TIMEOUT-1; the abort fires before it could wrap.
  localparam int unsigned   CW       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit            TO_EN    = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   paddr_d, pwdata_d, rsp_rdata_d;
  logic          pwrite_d, psel_d, penable_d, rsp_valid_d, rsp_err_d;

  // Only unregistered output: a command is taken whenever the bridge is idle.
  assign cmd_ready = (state_q == S_IDLE);

  // Next-state and next-output decode; APB pins and response are registered below.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    paddr_d     = PADDR;
    pwrite_d    = PWRITE;
    pwdata_d    = PWDATA;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    case (state_q)
      S_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          psel_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          // A ready slave always wins over a timeout landing in the same cycle.
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = PWRITE ? 32'h0 : PRDATA;
          state_d     = S_IDLE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = ERR_RDATA;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State, wait counter and every registered output; reset drops PSEL/PENABLE at once.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      PADDR     <= 32'h0;
      PWRITE    <= 1'b0;
      PWDATA    <= 32'h0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      PADDR     <= paddr_d;
      PWRITE    <= pwrite_d;
      PWDATA    <= pwdata_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - scoreboard bench for apb_master_bridge
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PSEL;
  logic        PENABLE;
  logic        PREADY;
  logic [31:0] PRDATA = 32'h0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   wait_n = 0;
  int   acc_cnt = 0;
  int   rsp_count = 0;
  int   dbl_pulse = 0;
  logic prev_rsp = 1'b0;

  apb_master_bridge #(.TIMEOUT(4), .ERR_RDATA(32'hDEADBEEF)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  // Slave model: ready after wait_n stalled ACCESS cycles; wait_n < 0 never ready.
  assign PREADY = (wait_n >= 0) && (acc_cnt >= wait_n);

  always @(posedge PCLK) begin
    if (PSEL && PENABLE) acc_cnt <= acc_cnt + 1;
    else                 acc_cnt <= 0;
  end

  always @(negedge PCLK) begin
    if (rsp_valid) rsp_count <= rsp_count + 1;
    if (rsp_valid && prev_rsp) dbl_pulse <= dbl_pulse + 1;
    prev_rsp <= rsp_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge PCLK);
      if (cmd_ready === 1'b1) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_ready: cmd_ready got %b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int cyc, output int acc, output bit stable, output logic psel_rsp);
    cyc = -1; acc = 0; stable = 1; psel_rsp = 1'bx;
    for (int i = 1; i <= 40 && cyc < 0; i++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        acc++;
        if (PADDR !== a || PWRITE !== w || PWDATA !== d) stable = 0;
      end
      if (rsp_valid === 1'b1) begin
        cyc = i;
        psel_rsp = PSEL;
      end
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err}); end
    checks++; if ({PADDR, PWDATA, rsp_rdata} !== 96'h0) begin errors++;
      $display("FAIL reset_data: got %h expected 0", {PADDR, PWDATA, rsp_rdata}); end
    checks++; if (cmd_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    PRESETn = 1'b1;
  endtask

  task automatic test_write_zero();
    rsp_t e;
    wait_n = 0;
    sb.push_back('{err: 1'b0, rdata: 32'h0});
    send(1'b1, 32'h0, 32'h1234_5678);
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE} !== 2'b10) begin errors++;
      $display("FAIL wr_setup: psel/penable got %b expected 10", {PSEL, PENABLE}); end
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE, PWRITE, PWDATA} !== {3'b111, 32'h1234_5678}) begin errors++;
      $display("FAIL wr_access: got %b %h expected 111 12345678", {PSEL, PENABLE, PWRITE}, PWDATA); end
    @(negedge PCLK);
    checks++; if ({rsp_valid, cmd_ready} !== 2'b11) begin errors++;
      $display("FAIL wr_rsp_cycle: valid/ready got %b expected 11", {rsp_valid, cmd_ready}); end
    e = sb.pop_front();
    checks++; if ({rsp_err, rsp_rdata} !== {e.err, e.rdata}) begin errors++;
      $display("FAIL wr_rsp: got %b %h expected %b %h", rsp_err, rsp_rdata, e.err, e.rdata); end
  endtask

  task automatic test_read_zero();
    rsp_t e; int cyc, acc; bit st; logic ps;
    wait_n = 0; PRDATA = 32'hA5A5_0001;
    sb.push_back('{err: 1'b0, rdata: 32'hA5A5_0001});
    send(1'b0, 32'h0, 32'h0);
    wait_rsp(1'b0, 32'h0, 32'h0, cyc, acc, st, ps);
    checks++; if (cyc !== 3) begin errors++;
      $display("FAIL rd_latency: got %0d expected 3", cyc); end
    e = sb.pop_front();
    checks++; if ({rsp_err, rsp_rdata} !== {e.err, e.rdata}) begin errors++;
      $display("FAIL rd_rsp: got %b %h expected %b %h", rsp_err, rsp_rdata, e.err, e.rdata); end
  endtask

  task automatic test_wait_states();
    rsp_t e; int cyc, acc; bit st; logic ps;
    wait_n = 3;
    sb.push_back('{err: 1'b0, rdata: 32'h0});
    send(1'b1, 32'h0000_0104, 32'hCAFE_0042);
    wait_rsp(1'b1, 32'h0000_0104, 32'hCAFE_0042, cyc, acc, st, ps);
    checks++; if ({cyc, acc} !== {32'd6, 32'd4}) begin errors++;
      $display("FAIL ws_timing: latency %0d access %0d expected 6 4", cyc, acc); end
    checks++; if (st !== 1'b1) begin errors++;
      $display("FAIL ws_stable: got %b expected 1", st); end
    e = sb.pop_front();
    checks++; if ({rsp_err, rsp_rdata} !== {e.err, e.rdata}) begin errors++;
      $display("FAIL ws_rsp: got %b %h expected %b %h", rsp_err, rsp_rdata, e.err, e.rdata); end
  endtask

  task automatic test_timeout();
    rsp_t e; int cyc, acc; bit st; logic ps;
    wait_n = -1; PRDATA = 32'h1111_2222;
    sb.push_back('{err: 1'b1, rdata: 32'hDEADBEEF});
    send(1'b0, 32'h0000_0040, 32'h0);
    wait_rsp(1'b0, 32'h0000_0040, 32'h0, cyc, acc, st, ps);
    checks++; if ({cyc, acc} !== {32'd6, 32'd4}) begin errors++;
      $display("FAIL to_timing: latency %0d access %0d expected 6 4", cyc, acc); end
    checks++; if (ps !== 1'b0) begin errors++;
      $display("FAIL to_psel: got %b expected 0", ps); end
    e = sb.pop_front();
    checks++; if ({rsp_err, rsp_rdata} !== {e.err, e.rdata}) begin errors++;
      $display("FAIL to_rsp: got %b %h expected %b %h", rsp_err, rsp_rdata, e.err, e.rdata); end
    @(negedge PCLK);
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 32'hDEADBEEF}) begin errors++;
      $display("FAIL to_hold: got %b %b %h expected 0 1 deadbeef", rsp_valid, rsp_err, rsp_rdata); end
    // PREADY arriving on the last allowed ACCESS cycle completes normally.
    wait_n = 3; PRDATA = 32'h0BAD_F00D;
    sb.push_back('{err: 1'b0, rdata: 32'h0BAD_F00D});
    send(1'b0, 32'h0000_0044, 32'h0);
    wait_rsp(1'b0, 32'h0000_0044, 32'h0, cyc, acc, st, ps);
    checks++; if ({cyc, acc} !== {32'd6, 32'd4}) begin errors++;
      $display("FAIL edge_timing: latency %0d access %0d expected 6 4", cyc, acc); end
    e = sb.pop_front();
    checks++; if ({rsp_err, rsp_rdata} !== {e.err, e.rdata}) begin errors++;
      $display("FAIL edge_rsp: got %b %h expected %b %h", rsp_err, rsp_rdata, e.err, e.rdata); end
  endtask

  task automatic test_back_to_back();
    rsp_t e; logic [5:0] pat; int nrsp = 0; bit rdy = 0;
    wait_n = 0; PRDATA = 32'h7777_0002;
    sb.push_back('{err: 1'b0, rdata: 32'h0});
    sb.push_back('{err: 1'b0, rdata: 32'h7777_0002});
    for (int i = 0; i < 20 && !rdy; i++) begin
      @(negedge PCLK);
      if (cmd_ready === 1'b1) rdy = 1;
    end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0200; cmd_wdata = 32'h5555_AAAA;
    @(posedge PCLK);
    for (int i = 1; i <= 6; i++) begin
      @(negedge PCLK);
      if (i == 1) begin cmd_write = 1'b0; cmd_addr = 32'h0000_0300; cmd_wdata = 32'h0; end
      pat[i-1] = PSEL;
      if (i == 4) begin
        cmd_valid = 1'b0;
        checks++; if ({PADDR, PWRITE} !== {32'h0000_0300, 1'b0}) begin errors++;
          $display("FAIL b2b_second_cmd: got %h %b expected 00000300 0", PADDR, PWRITE); end
      end
      if (rsp_valid === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        nrsp++;
        checks++; if ({rsp_err, rsp_rdata} !== {e.err, e.rdata}) begin errors++;
          $display("FAIL b2b_rsp%0d: got %b %h expected %b %h", nrsp, rsp_err, rsp_rdata, e.err, e.rdata); end
      end
    end
    checks++; if (pat !== 6'b011011) begin errors++;
      $display("FAIL b2b_psel_pattern: got %b expected 011011", pat); end
    checks++; if (nrsp !== 2) begin errors++;
      $display("FAIL b2b_rsp_count: got %0d expected 2", nrsp); end
  endtask

  task automatic test_reset_in_access();
    int snap;
    wait_n = -1;
    send(1'b0, 32'h0000_0500, 32'h0);
    @(negedge PCLK);
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE} !== 2'b11) begin errors++;
      $display("FAIL rst_pre_access: got %b expected 11", {PSEL, PENABLE}); end
    #2 PRESETn = 1'b0;
    #1;
    snap = rsp_count;
    checks++; if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin errors++;
      $display("FAIL rst_async: got %b expected 000", {PSEL, PENABLE, rsp_valid}); end
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    wait_n = 0;
    repeat (6) @(negedge PCLK);
    checks++; if (cmd_ready !== 1'b1) begin errors++;
      $display("FAIL rst_idle: cmd_ready got %b expected 1", cmd_ready); end
    checks++; if (rsp_count !== snap) begin errors++;
      $display("FAIL rst_spurious: rsp pulses got %0d expected %0d", rsp_count, snap); end
  endtask

  initial begin
    test_reset();
    test_write_zero();
    test_read_zero();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_reset_in_access();
    checks++; if (dbl_pulse !== 0) begin errors++;
      $display("FAIL rsp_pulse_width: wide pulses got %0d expected 0", dbl_pulse); end
    checks++; if (sb.size() !== 0) begin errors++;
      $display("FAIL scoreboard_drain: leftover %0d expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB initiator that converts a simple valid/ready command port into APB SETUP/ACCESS transfers.
- It is the counterpart of the team's APB register slaves. It drives PSEL, PENABLE, PADDR, PWRITE and PWDATA, and waits on PREADY.
- It returns read data and an error flag through a one-cycle response pulse.
- It sits between the CPU-side bus adapter and the APB peripheral segment.

Parameters:
- TIMEOUT, 16, number of ACCESS cycles with PREADY low before the transfer is aborted. 0 disables the timeout.
- ERR_RDATA, 32'hDEADBEEF, value returned on rsp_rdata when a transfer is aborted by timeout.

Ports:
- PCLK  input  1  APB clock; the only clock in the block.
- PRESETn  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  bridge can accept a command (high only in IDLE).
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  32  transfer address.
- cmd_wdata  input  32  write data.
- rsp_valid  output  1  one-cycle pulse marking transfer completion.
- rsp_rdata  output  32  read data; 0 for writes; ERR_RDATA on timeout.
- rsp_err  output  1  1 = timeout abort; valid with rsp_valid.
- PADDR  output  32  APB address.
- PWRITE  output  1  APB direction.
- PWDATA  output  32  APB write data.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PREADY  input  1  APB ready from the slave.
- PRDATA  input  32  APB read data from the slave.

Behaviour:
- Reset (async, PRESETn low):
  - state = IDLE.
  - PSEL, PENABLE, PWRITE, rsp_valid and rsp_err = 0.
  - PADDR, PWDATA and rsp_rdata = 0.
  - Timeout counter = 0.
- All outputs are registered except cmd_ready, which is decoded as state == IDLE.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - PSEL = 0, PENABLE = 0.
  - On cmd_valid & cmd_ready at a clock edge:
    - latch cmd_addr into PADDR, cmd_write into PWRITE, cmd_wdata into PWDATA;
    - go to SETUP.
  - PADDR, PWRITE and PWDATA hold their last values while idle.
- SETUP:
  - PSEL = 1, PENABLE = 0, for exactly one cycle.
  - Clear the counter and go to ACCESS.
- ACCESS:
  - PSEL = 1, PENABLE = 1. PADDR, PWRITE and PWDATA are stable.
  - If PREADY = 1:
    - the next cycle has rsp_valid = 1 and rsp_err = 0;
    - rsp_rdata = PRDATA sampled at that edge for reads, 32'h0 for writes;
    - PSEL and PENABLE drop to 0 and the state returns to IDLE.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1:
    - abort: the next cycle has rsp_valid = 1, rsp_err = 1, rsp_rdata = ERR_RDATA;
    - PSEL and PENABLE drop to 0 and the state returns to IDLE.
  - Else: counter increments and the bridge stays in ACCESS.
  - PREADY = 1 in the same cycle the timeout would fire counts as a normal completion (PREADY wins).
- Latency:
  - Command accepted at edge N.
  - SETUP in cycle N+1.
  - ACCESS in cycle N+2.
  - With zero wait states, rsp_valid and cmd_ready are both high in cycle N+3.
  - Minimum 3 cycles per transfer. Back-to-back commands are accepted at the edge ending cycle N+3.
- rsp_valid is a pulse, always exactly one cycle. It is not back-pressured. rsp_rdata and rsp_err hold their values until the next completion.
- cmd_* inputs are ignored outside IDLE. At most one transfer is outstanding.
- Counter width is clog2(TIMEOUT+1), minimum 1. There is no wrap-around, because the abort fires before overflow.
- Reset asserted mid-transfer:
  - PSEL and PENABLE drop immediately (asynchronously).
  - No rsp_valid is generated for the abandoned transfer.

Test Plan:
- Zero-wait write: cmd write addr=0x0000_0000, wdata=0x1234_5678, PREADY tied 1.
  - Cycle N+1: PSEL=1, PENABLE=0.
  - Cycle N+2: PSEL=1, PENABLE=1, PWDATA=0x1234_5678.
  - Cycle N+3: rsp_valid=1, rsp_err=0, rsp_rdata=0, cmd_ready=1.
- Zero-wait read: addr=0x0000_0000, slave PRDATA=0xA5A5_0001.
  - rsp_rdata=0xA5A5_0001 at N+3.
- Wait states: PREADY low for 3 ACCESS cycles, then high.
  - ACCESS lasts 4 cycles with PADDR, PWRITE and PWDATA stable.
  - rsp_valid at N+6, rsp_err=0.
- Timeout, TIMEOUT=4, PREADY held 0.
  - Exactly 4 ACCESS cycles.
  - rsp_valid=1, rsp_err=1, rsp_rdata=0xDEADBEEF.
  - PSEL=0 in the response cycle.
  - Repeat with PREADY=1 on the 4th ACCESS cycle: rsp_err=0.
- Back-to-back: cmd_valid held high for 2 commands.
  - Second SETUP occurs at N+4. No PSEL gap beyond one IDLE cycle.
- Reset in ACCESS: pull PRESETn low.
  - PSEL, PENABLE and rsp_valid = 0 immediately.
  - After release: state IDLE, cmd_ready=1, no spurious rsp_valid.
